// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern constants and frame decoder state type
package seg7_pkg;

    // Active-low segment patterns, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h18;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to hex nibble decoder
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       illegal_o
);

    // Exact-match lookup; anything not in the table decodes to 0 and is flagged
    always_comb begin
        nibble_o  = 4'h0;
        illegal_o = 1'b0;
        case (seg_i)
            SEG_HEX_0: nibble_o = 4'h0;
            SEG_HEX_1: nibble_o = 4'h1;
            SEG_HEX_2: nibble_o = 4'h2;
            SEG_HEX_3: nibble_o = 4'h3;
            SEG_HEX_4: nibble_o = 4'h4;
            SEG_HEX_5: nibble_o = 4'h5;
            SEG_HEX_6: nibble_o = 4'h6;
            SEG_HEX_7: nibble_o = 4'h7;
            SEG_HEX_8: nibble_o = 4'h8;
            SEG_HEX_9: nibble_o = 4'h9;
            SEG_HEX_A: nibble_o = 4'hA;
            SEG_HEX_B: nibble_o = 4'hB;
            SEG_HEX_C: nibble_o = 4'hC;
            SEG_HEX_D: nibble_o = 4'hD;
            SEG_HEX_E: nibble_o = 4'hE;
            SEG_HEX_F: nibble_o = 4'hF;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// rtl/seg7_frame_decoder.sv - assembles decoded seven-segment digits into handshaked words
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    input  logic                    seg_first,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic [NUM_DIGITS-1:0]   word_err_mask,
    output logic                    word_err,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    resync,
    output logic                    drop
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    seg7_state_e            state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [W-1:0]           word_q, word_d;
    logic [NUM_DIGITS-1:0]  mask_q, mask_d;
    logic                   resync_q, resync_d;
    logic                   drop_q, drop_d;

    logic [3:0]             nibble;
    logic                   illegal;
    logic                   accept;

    seg7_pattern_decode u_decode (
        .seg_i     (seg_in),
        .nibble_o  (nibble),
        .illegal_o (illegal)
    );

    // Ready and valid come from state alone so no input reaches them combinationally
    assign seg_ready     = (state_q != HOLD);
    assign word_valid    = (state_q == HOLD);
    assign accept        = seg_valid & seg_ready;
    assign word_out      = word_q;
    assign word_err_mask = mask_q;
    assign word_err      = |mask_q;
    assign resync        = resync_q;
    assign drop          = drop_q;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            word_q   <= '0;
            mask_q   <= '0;
            resync_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            word_q   <= word_d;
            mask_q   <= mask_d;
            resync_q <= resync_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state: a first digit always restarts the frame at index 0; the mask shifts
    // alongside the word so the first digit's error bit ends up in the top position
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        word_d   = word_q;
        mask_d   = mask_q;
        resync_d = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (seg_first) begin
                        word_d  = W'(nibble);
                        mask_d  = NUM_DIGITS'(illegal);
                        count_d = CW'(1);
                        state_d = (NUM_DIGITS == 1) ? HOLD : COLLECT;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (seg_first) begin
                        word_d   = W'(nibble);
                        mask_d   = NUM_DIGITS'(illegal);
                        count_d  = CW'(1);
                        resync_d = 1'b1;
                        state_d  = (NUM_DIGITS == 1) ? HOLD : COLLECT;
                    end else begin
                        word_d  = (word_q << 4) | W'(nibble);
                        mask_d  = (mask_q << 1) | NUM_DIGITS'(illegal);
                        count_d = count_q + CW'(1);
                        if (count_q + CW'(1) == CW'(NUM_DIGITS)) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb/tb_seg7_frame_decoder.sv - directed self-checking bench for seg7_frame_decoder
module tb_seg7_frame_decoder;

    logic        clk;
    logic        resetn;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_first;
    logic        seg_ready;
    logic [15:0] word_out;
    logic [3:0]  word_err_mask;
    logic        word_err;
    logic        word_valid;
    logic        word_ready;
    logic        resync;
    logic        drop;

    int total;
    int bad;

    seg7_frame_decoder #(.NUM_DIGITS(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .seg_in        (seg_in),
        .seg_valid     (seg_valid),
        .seg_first     (seg_first),
        .seg_ready     (seg_ready),
        .word_out      (word_out),
        .word_err_mask (word_err_mask),
        .word_err      (word_err),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .resync        (resync),
        .drop          (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [6:0] pat, input logic first);
        int waited;
        waited = 0;
        while (!seg_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("ready_wait", {31'd0, seg_ready}, 32'd1);
        seg_in    = pat;
        seg_first = first;
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
        seg_first = 1'b0;
    endtask

    // Sends one full frame; checks valid is low before the last digit and high right after it
    task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3, input string tag);
        send_digit(p0, 1'b1);
        send_digit(p1, 1'b0);
        send_digit(p2, 1'b0);
        chk({tag, "_valid_pre"}, {31'd0, word_valid}, 32'd0);
        send_digit(p3, 1'b0);
        chk({tag, "_valid_lat"}, {31'd0, word_valid}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_word"},  {16'd0, word_out}, 32'd0);
        chk({tag, "_mask"},  {28'd0, word_err_mask}, 32'd0);
        chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, seg_ready}, 32'd1);
        chk({tag, "_resync"}, {31'd0, resync}, 32'd0);
        chk({tag, "_drop"},  {31'd0, drop}, 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resetn     = 1'b0;
        seg_in     = 7'h7F;
        seg_valid  = 1'b0;
        seg_first  = 1'b0;
        word_ready = 1'b1;
        tick();
        tick();
        check_reset_state("rst");
        resetn = 1'b1;
        tick();

        // Basic frame 1,2,3,4
        send_frame(7'h79, 7'h24, 7'h30, 7'h19, "f1234");
        chk("f1234_word", {16'd0, word_out}, 32'h1234);
        chk("f1234_err",  {31'd0, word_err}, 32'd0);
        tick();
        chk("f1234_valid_drop", {31'd0, word_valid}, 32'd0);
        chk("f1234_word_keep", {16'd0, word_out}, 32'h1234);

        // All sixteen legal patterns across four frames
        send_frame(7'h40, 7'h79, 7'h24, 7'h30, "f0123");
        chk("f0123_word", {16'd0, word_out}, 32'h0123);
        chk("f0123_err",  {31'd0, word_err}, 32'd0);
        tick();
        send_frame(7'h19, 7'h12, 7'h02, 7'h78, "f4567");
        chk("f4567_word", {16'd0, word_out}, 32'h4567);
        chk("f4567_err",  {31'd0, word_err}, 32'd0);
        tick();
        send_frame(7'h00, 7'h18, 7'h08, 7'h03, "f89ab");
        chk("f89ab_word", {16'd0, word_out}, 32'h89AB);
        chk("f89ab_err",  {31'd0, word_err}, 32'd0);
        tick();
        send_frame(7'h46, 7'h21, 7'h06, 7'h0E, "fcdef");
        chk("fcdef_word", {16'd0, word_out}, 32'hCDEF);
        chk("fcdef_err",  {31'd0, word_err}, 32'd0);
        tick();

        // Illegal pattern in the second digit
        send_frame(7'h40, 7'h7F, 7'h00, 7'h0E, "fill");
        chk("fill_word", {16'd0, word_out}, 32'h008F);
        chk("fill_mask", {28'd0, word_err_mask}, 32'b0100);
        chk("fill_err",  {31'd0, word_err}, 32'd1);
        tick();

        // Backpressure in HOLD with a digit waiting
        word_ready = 1'b0;
        send_frame(7'h79, 7'h24, 7'h30, 7'h19, "fbp");
        seg_in    = 7'h40;
        seg_first = 1'b1;
        seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", {31'd0, seg_ready}, 32'd0);
            chk("bp_valid", {31'd0, word_valid}, 32'd1);
            chk("bp_word",  {16'd0, word_out}, 32'h1234);
        end
        word_ready = 1'b1;
        tick();
        seg_valid = 1'b0;
        seg_first = 1'b0;
        chk("bp_release_valid", {31'd0, word_valid}, 32'd0);
        chk("bp_release_word",  {16'd0, word_out}, 32'h1234);
        chk("bp_release_ready", {31'd0, seg_ready}, 32'd1);
        send_frame(7'h12, 7'h02, 7'h78, 7'h00, "f5678");
        chk("f5678_word", {16'd0, word_out}, 32'h5678);
        tick();

        // Mid-frame restart after two digits
        send_digit(7'h79, 1'b1);
        send_digit(7'h24, 1'b0);
        send_digit(7'h30, 1'b1);
        chk("resync_pulse", {31'd0, resync}, 32'd1);
        send_digit(7'h19, 1'b0);
        chk("resync_clear", {31'd0, resync}, 32'd0);
        send_digit(7'h12, 1'b0);
        chk("resync_valid_pre", {31'd0, word_valid}, 32'd0);
        send_digit(7'h02, 1'b0);
        chk("resync_valid", {31'd0, word_valid}, 32'd1);
        chk("resync_word",  {16'd0, word_out}, 32'h3456);
        tick();

        // Stray digit in IDLE
        send_digit(7'h00, 1'b0);
        chk("drop_pulse", {31'd0, drop}, 32'd1);
        chk("drop_word",  {16'd0, word_out}, 32'h3456);
        chk("drop_valid", {31'd0, word_valid}, 32'd0);
        tick();
        chk("drop_clear", {31'd0, drop}, 32'd0);

        // Reset mid-COLLECT
        send_digit(7'h79, 1'b1);
        send_digit(7'h24, 1'b0);
        resetn = 1'b0;
        tick();
        check_reset_state("rst_coll");
        resetn = 1'b1;
        send_frame(7'h08, 7'h03, 7'h46, 7'h21, "fabcd");
        chk("fabcd_word", {16'd0, word_out}, 32'hABCD);
        tick();

        // Reset during HOLD
        word_ready = 1'b0;
        send_frame(7'h06, 7'h0E, 7'h40, 7'h79, "fef01");
        chk("fef01_word", {16'd0, word_out}, 32'hEF01);
        resetn = 1'b0;
        tick();
        check_reset_state("rst_hold");
        resetn     = 1'b1;
        word_ready = 1'b1;
        send_frame(7'h18, 7'h78, 7'h02, 7'h12, "f9765");
        chk("f9765_word", {16'd0, word_out}, 32'h9765);
        chk("f9765_err",  {31'd0, word_err}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
